// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: mode codes and one-shot FSM states.
package prog_counter_pkg;

    // Wrap policy selected by the mode input
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    // One-shot sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } os_state_t;

    // True when the mode code selects the one-shot policy
    function automatic logic is_oneshot(input logic [1:0] mode_code);
        return (mode_code == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/prog_counter_oneshot_fsm.sv
// One-shot sequencer: IDLE -> RUN on start, RUN -> DONE on an enabled terminal
// step, DONE -> RUN on start. Leaving one-shot mode forces IDLE on the next edge.
// The reload request tells the datapath to restart the count from its origin.
module prog_counter_oneshot_fsm
    import prog_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_start,
    input  logic       i_term,
    input  logic [1:0] i_mode,
    output logic [1:0] o_state,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_reload
);

    os_state_t r_state;
    os_state_t w_state_next;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and reload request; start always wins over a terminal step
    always_comb begin
        w_state_next = r_state;
        o_reload     = 1'b0;
        if (!is_oneshot(i_mode)) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        o_reload     = 1'b1;
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (i_start) begin
                        o_reload     = 1'b1;
                        w_state_next = RUN;
                    end else if (i_term) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    if (i_start) begin
                        o_reload     = 1'b1;
                        w_state_next = RUN;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_state = r_state;
        case (r_state)
            RUN:     o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with terminal value, synchronous load and
// wrap / saturate / one-shot / hold policies. Produces a registered
// terminal-count pulse and a sticky overflow flag.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_next;
    logic             w_tc_next;
    logic             w_ovf_next;
    logic             w_ovf_set;
    logic             w_term;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_origin_val;
    logic             w_os_start;
    logic             w_os_term;
    logic             w_os_reload;
    logic [1:0]       w_os_state;

    // Terminal condition on the current count; dir and limit act immediately
    assign w_term = dir ? (r_count >= limit) : (r_count == '0);

    // Plain +/-1 step, modulo 2^WIDTH
    assign w_step_val = dir ? (r_count + ONE) : (r_count - ONE);

    // Value the count restarts from after a wrap or one-shot (re)start
    assign w_origin_val = dir ? '0 : limit;

    // Load outranks start and the terminal step, so mask both from the sequencer
    assign w_os_start = start & ~load;
    assign w_os_term  = en & w_term & ~load;

    prog_counter_oneshot_fsm u_oneshot_fsm (
        .clk      (clk),
        .rstn     (rstn),
        .i_start  (w_os_start),
        .i_term   (w_os_term),
        .i_mode   (mode),
        .o_state  (w_os_state),
        .o_busy   (busy),
        .o_done   (done),
        .o_reload (w_os_reload)
    );

    // Next count, terminal pulse and overflow set, by priority load > start > step
    always_comb begin
        w_count_next = r_count;
        w_tc_next    = 1'b0;
        w_ovf_set    = 1'b0;
        if (load) begin
            w_count_next = load_val;
        end else begin
            case (mode)
                MODE_WRAP: begin
                    if (en) begin
                        if (w_term) begin
                            w_count_next = w_origin_val;
                            w_tc_next    = 1'b1;
                            w_ovf_set    = 1'b1;
                        end else begin
                            w_count_next = w_step_val;
                        end
                    end
                end
                MODE_SAT: begin
                    if (en) begin
                        if (w_term) begin
                            w_tc_next = 1'b1;
                            w_ovf_set = 1'b1;
                        end else begin
                            w_count_next = w_step_val;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (w_os_reload) begin
                        w_count_next = w_origin_val;
                    end else if ((w_os_state == RUN) && en) begin
                        if (w_term) begin
                            w_tc_next = 1'b1;
                        end else begin
                            w_count_next = w_step_val;
                        end
                    end
                end
                default: begin
                    // Hold: count frozen, no terminal events
                end
            endcase
        end
    end

    // Sticky overflow: a new event beats a simultaneous clear
    assign w_ovf_next = w_ovf_set | (r_ovf & ~clr_ovf);

    // Datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= RST_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tc    <= w_tc_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule
